// File: rtl/uart_ctrl.sv
// Bus-side UART controller: RX FIFO, TX sequencer, STATUS/DATA/CTRL registers, irq.
// Optional loopback path (CTRL[2]) is compiled in only with UART_CTRL_LOOPBACK_EN defined.
module uart_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_cs,
    input  logic       bus_we,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_wr_data,
    output logic [7:0] bus_rd_data,
    output logic       bus_rdy,
    output logic       irq,
    input  logic       rx_end,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_end
);

    localparam logic [1:0]       ADDR_STATUS = 2'd0;
    localparam logic [1:0]       ADDR_DATA   = 2'd1;
    localparam logic [1:0]       ADDR_CTRL   = 2'd2;
    localparam logic [FIFO_AW:0] PTR_ONE     = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT
    } tx_state_t;

    tx_state_t        r_state;
    tx_state_t        w_next;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic [2:0]       r_ctrl;
    logic             r_overrun;
    logic             r_tx_done;
    logic [7:0]       r_tx_data;
    logic [7:0]       r_rd_data;
    logic             r_rdy;
    logic             r_irq;

    logic       w_empty;
    logic       w_full;
    logic       w_rd;
    logic       w_wr;
    logic       w_data_wr;
    logic       w_pop;
    logic       w_push_req;
    logic [7:0] w_push_data;
    logic       w_push_ok;
    logic       w_ext_lost;
    logic       w_ovr_set;
    logic       w_tx_wr;
    logic       w_lb_done;
    logic       w_tx_start;
    logic       w_tx_load;
    logic       w_tx_done_set;
    logic       w_tx_busy;
    logic [7:0] w_status;
    logic [7:0] w_rd_mux;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                       (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_rd      = bus_cs & ~bus_we;
    assign w_wr      = bus_cs & bus_we;
    assign w_data_wr = w_wr && (bus_addr == ADDR_DATA);
    assign w_pop     = w_rd && (bus_addr == ADDR_DATA) && !w_empty;

`ifdef UART_CTRL_LOOPBACK_EN
    logic w_lb_push;
    // A loopback byte takes the single push slot; a coincident external byte is lost.
    assign w_lb_push   = w_data_wr & r_ctrl[2];
    assign w_push_req  = w_lb_push | rx_end;
    assign w_push_data = w_lb_push ? bus_wr_data : rx_data;
    assign w_ext_lost  = w_lb_push & rx_end;
    assign w_tx_wr     = w_data_wr & ~r_ctrl[2];
    assign w_lb_done   = w_lb_push;
`else
    assign w_push_req  = rx_end;
    assign w_push_data = rx_data;
    assign w_ext_lost  = 1'b0;
    assign w_tx_wr     = w_data_wr;
    assign w_lb_done   = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a push into a full FIFO is not lost.
    assign w_push_ok = w_push_req && (!w_full || w_pop);
    assign w_ovr_set = (w_push_req && w_full && !w_pop) || w_ext_lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_tx_start    = 1'b0;
        w_tx_load     = 1'b0;
        w_tx_done_set = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (w_tx_wr) begin
                    w_next    = TX_START;
                    w_tx_load = 1'b1;
                end
            end
            TX_START: begin
                w_tx_start = 1'b1;
                w_next     = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_end) begin
                    w_next        = TX_IDLE;
                    w_tx_done_set = 1'b1;
                end
            end
            default: w_next = TX_IDLE;
        endcase
    end

    assign w_tx_busy = (r_state != TX_IDLE);
    assign w_status  = {3'b000, r_tx_done, w_tx_busy, r_overrun, w_full, ~w_empty};

    always_comb begin
        w_rd_mux = '0;
        case (bus_addr)
            ADDR_STATUS: w_rd_mux = w_status;
            ADDR_DATA:   w_rd_mux = w_empty ? 8'h00 : r_mem[r_rd_ptr[FIFO_AW-1:0]];
            ADDR_CTRL:   w_rd_mux = {5'b00000, r_ctrl};
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_rdy     <= 1'b0;
            r_ctrl    <= '0;
            r_overrun <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx_data <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_rdy     <= bus_cs;
            r_rd_data <= w_rd ? w_rd_mux : 8'h00;
            if (w_wr && (bus_addr == ADDR_CTRL)) begin
`ifdef UART_CTRL_LOOPBACK_EN
                r_ctrl <= bus_wr_data[2:0];
`else
                r_ctrl <= {1'b0, bus_wr_data[1:0]};
`endif
            end
            // Set has priority over write-1-clear for both sticky flags.
            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (w_wr && (bus_addr == ADDR_STATUS) && bus_wr_data[2])
                r_overrun <= 1'b0;
            if (w_tx_done_set || w_lb_done)
                r_tx_done <= 1'b1;
            else if (w_wr && (bus_addr == ADDR_STATUS) && bus_wr_data[4])
                r_tx_done <= 1'b0;
            if (w_tx_load) r_tx_data <= bus_wr_data;
            r_irq <= (r_ctrl[0] & ~w_empty) | (r_ctrl[1] & r_tx_done);
        end
    end

    assign bus_rd_data = r_rd_data;
    assign bus_rdy     = r_rdy;
    assign irq         = r_irq;
    assign tx_start    = w_tx_start;
    assign tx_data     = r_tx_data;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: a byte-queue model of the RX FIFO plus
// TX/sticky-flag model state supplies every expected value.
module tb_uart_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_cs;
    logic       bus_we;
    logic [1:0] bus_addr;
    logic [7:0] bus_wr_data;
    logic [7:0] bus_rd_data;
    logic       bus_rdy;
    logic       irq;
    logic       rx_end;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_end;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [7:0] m_fifo [$];
    bit         m_ovr;
    bit         m_busy;
    bit         m_txdone;
    logic [7:0] rd;
    logic       rdy;
    logic [7:0] exp;

    uart_ctrl #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk(clk), .rst(rst), .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy), .irq(irq),
        .rx_end(rx_end), .rx_data(rx_data), .tx_start(tx_start), .tx_data(tx_data),
        .tx_end(tx_end)
    );

    always #5 clk = ~clk;

    task automatic bus_access(input bit we, input logic [1:0] a, input logic [7:0] wd);
        @(posedge clk); #1;
        bus_cs = 1'b1; bus_we = we; bus_addr = a; bus_wr_data = wd;
        @(posedge clk); #1;
        bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wr_data = 8'h00;
        rd = bus_rd_data; rdy = bus_rdy;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(posedge clk); #1; rx_end = 1'b1; rx_data = d;
        @(posedge clk); #1; rx_end = 1'b0; rx_data = 8'h00;
    endtask

    task automatic model_push(input logic [7:0] d);
        if (m_fifo.size() < 8) m_fifo.push_back(d);
        else m_ovr = 1'b1;
    endtask

    function automatic logic [7:0] model_status();
        return {3'b000, m_txdone, m_busy, m_ovr, m_fifo.size() == 8, m_fifo.size() != 0};
    endfunction

    task automatic test_reset;
        n_cmp++; if (irq !== 1'b0 || tx_start !== 1'b0 || bus_rdy !== 1'b0 || bus_rd_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs got irq=%b txs=%b rdy=%b rd=%02h exp all 0", irq, tx_start, bus_rdy, bus_rd_data);
        end
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_status_rdy got=%b exp=1", rdy); end
        n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_status got=%02h exp=00", rd); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(posedge clk); #1;
        n_cmp++; if (bus_rdy !== 1'b0 || bus_rd_data !== 8'h00) begin
            n_fail++; $display("FAIL idle_bus got rdy=%b rd=%02h exp 0/00", bus_rdy, bus_rd_data);
        end
    endtask

    task automatic test_regs;
        bus_access(1'b1, 2'd3, 8'hFF);
        n_cmp++; if (rdy !== 1'b1 || rd !== 8'h00) begin n_fail++; $display("FAIL write_ack got rdy=%b rd=%02h exp 1/00", rdy, rd); end
        bus_access(1'b0, 2'd3, 8'h00);
        n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reserved_rd got=%02h exp=00", rd); end
        bus_access(1'b1, 2'd2, 8'hFF);
        bus_access(1'b0, 2'd2, 8'h00);
`ifdef UART_CTRL_LOOPBACK_EN
        exp = 8'h07;
`else
        exp = 8'h03;
`endif
        n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL ctrl_rd got=%02h exp=%02h", rd, exp); end
        bus_access(1'b1, 2'd2, 8'h00);
    endtask

    task automatic test_rx_basic;
        rx_pulse(8'h41); model_push(8'h41);
        rx_pulse(8'h42); model_push(8'h42);
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== model_status()) begin n_fail++; $display("FAIL rx_status got=%02h exp=%02h", rd, model_status()); end
        for (int i = 0; i < 3; i++) begin
            exp = (m_fifo.size() != 0) ? m_fifo.pop_front() : 8'h00;
            bus_access(1'b0, 2'd1, 8'h00);
            n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL rx_data[%0d] got=%02h exp=%02h", i, rd, exp); end
        end
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rx_empty_status got=%02h exp=00", rd); end
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 9; i++) begin
            rx_pulse(8'(i)); model_push(8'(i));
        end
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== 8'h07 || rd !== model_status()) begin n_fail++; $display("FAIL ovr_status got=%02h exp=07", rd); end
        while (m_fifo.size() != 0) begin
            exp = m_fifo.pop_front();
            bus_access(1'b0, 2'd1, 8'h00);
            n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL ovr_data got=%02h exp=%02h", rd, exp); end
        end
        bus_access(1'b1, 2'd0, 8'h04); m_ovr = 1'b0;
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== model_status()) begin n_fail++; $display("FAIL ovr_clear got=%02h exp=%02h", rd, model_status()); end
    endtask

    task automatic test_pop_push;
        // Empty: simultaneous read returns 00 while the new byte is stored.
        @(posedge clk); #1;
        bus_cs = 1'b1; bus_we = 1'b0; bus_addr = 2'd1; rx_end = 1'b1; rx_data = 8'h66;
        @(posedge clk); #1;
        bus_cs = 1'b0; rx_end = 1'b0; rd = bus_rd_data;
        model_push(8'h66);
        n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL popush_empty got=%02h exp=00", rd); end
        exp = m_fifo.pop_front();
        bus_access(1'b0, 2'd1, 8'h00);
        n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL popush_empty_data got=%02h exp=%02h", rd, exp); end
        for (int i = 1; i <= 8; i++) begin
            rx_pulse(8'(i)); model_push(8'(i));
        end
        @(posedge clk); #1;
        bus_cs = 1'b1; bus_we = 1'b0; bus_addr = 2'd1; rx_end = 1'b1; rx_data = 8'h55;
        @(posedge clk); #1;
        bus_cs = 1'b0; rx_end = 1'b0; rd = bus_rd_data;
        exp = m_fifo.pop_front(); m_fifo.push_back(8'h55);
        n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL popush_full got=%02h exp=%02h", rd, exp); end
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== 8'h03 || rd !== model_status()) begin n_fail++; $display("FAIL popush_status got=%02h exp=03", rd); end
        while (m_fifo.size() != 0) begin
            exp = m_fifo.pop_front();
            bus_access(1'b0, 2'd1, 8'h00);
            n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL popush_data got=%02h exp=%02h", rd, exp); end
        end
    endtask

    task automatic test_rx_irq;
        bus_access(1'b1, 2'd2, 8'h01);
        rx_pulse(8'h77); model_push(8'h77);
        @(posedge clk); #1;
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rx_irq_set got=%b exp=1", irq); end
        exp = m_fifo.pop_front();
        bus_access(1'b0, 2'd1, 8'h00);
        n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL rx_irq_data got=%02h exp=%02h", rd, exp); end
        @(posedge clk); #1;
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_clr got=%b exp=0", irq); end
        bus_access(1'b1, 2'd2, 8'h00);
    endtask

    task automatic test_tx;
        @(posedge clk); #1; tx_end = 1'b1;
        @(posedge clk); #1; tx_end = 1'b0;
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== model_status()) begin n_fail++; $display("FAIL tx_end_idle got=%02h exp=%02h", rd, model_status()); end
        bus_access(1'b1, 2'd2, 8'h02);
        bus_access(1'b1, 2'd1, 8'hA5); m_busy = 1'b1;
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++; $display("FAIL tx_start got start=%b data=%02h exp 1/A5", tx_start, tx_data);
        end
        @(posedge clk); #1;
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL tx_pulse_len got=%b exp=0", tx_start); end
        bus_access(1'b1, 2'd1, 8'h5A);
        n_cmp++; if (tx_start !== 1'b0 || tx_data !== 8'hA5) begin
            n_fail++; $display("FAIL tx_busy_drop got start=%b data=%02h exp 0/A5", tx_start, tx_data);
        end
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== model_status()) begin n_fail++; $display("FAIL tx_busy_status got=%02h exp=%02h", rd, model_status()); end
        @(posedge clk); #1; tx_end = 1'b1;
        @(posedge clk); #1; tx_end = 1'b0; m_busy = 1'b0; m_txdone = 1'b1;
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== model_status()) begin n_fail++; $display("FAIL tx_done_status got=%02h exp=%02h", rd, model_status()); end
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tx_irq_set got=%b exp=1", irq); end
        bus_access(1'b1, 2'd0, 8'h10); m_txdone = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL tx_irq_clr got=%b exp=0", irq); end
        bus_access(1'b1, 2'd2, 8'h00);
    endtask

`ifdef UART_CTRL_LOOPBACK_EN
    task automatic test_loopback;
        bus_access(1'b1, 2'd2, 8'h05);
        bus_access(1'b1, 2'd1, 8'h3C); model_push(8'h3C); m_txdone = 1'b1;
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL lb_no_start got=%b exp=0", tx_start); end
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== model_status()) begin n_fail++; $display("FAIL lb_status got=%02h exp=%02h", rd, model_status()); end
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL lb_irq got=%b exp=1", irq); end
        exp = m_fifo.pop_front();
        bus_access(1'b0, 2'd1, 8'h00);
        n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL lb_data got=%02h exp=%02h", rd, exp); end
        bus_access(1'b1, 2'd0, 8'h10); m_txdone = 1'b0;
        bus_access(1'b1, 2'd2, 8'h00);
    endtask
`endif

    task automatic test_reset_mid_frame;
        rx_pulse(8'h21); model_push(8'h21);
        rx_pulse(8'h22); model_push(8'h22);
        bus_access(1'b1, 2'd2, 8'h03);
        bus_access(1'b1, 2'd1, 8'h77); m_busy = 1'b1;
        @(posedge clk); #1;
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== model_status()) begin n_fail++; $display("FAIL mid_status got=%02h exp=%02h", rd, model_status()); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        m_fifo.delete(); m_busy = 1'b0; m_txdone = 1'b0; m_ovr = 1'b0;
        n_cmp++; if (irq !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
            n_fail++; $display("FAIL mid_rst_out got irq=%b txs=%b txd=%02h exp 0/0/00", irq, tx_start, tx_data);
        end
        bus_access(1'b0, 2'd0, 8'h00);
        n_cmp++; if (rd !== model_status()) begin n_fail++; $display("FAIL mid_rst_status got=%02h exp=%02h", rd, model_status()); end
        bus_access(1'b0, 2'd2, 8'h00);
        n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_rst_ctrl got=%02h exp=00", rd); end
        bus_access(1'b0, 2'd1, 8'h00);
        n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got=%02h exp=00", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wr_data = 8'h00;
        rx_end = 1'b0; rx_data = 8'h00; tx_end = 1'b0;
        m_ovr = 1'b0; m_busy = 1'b0; m_txdone = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_regs();
        test_rx_basic();
        test_overrun();
        test_pop_push();
        test_rx_irq();
        test_tx();
`ifdef UART_CTRL_LOOPBACK_EN
        test_loopback();
`endif
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
